// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and stream framing constants.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE} state_t;
  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs four LSB-first bytes into one 32-bit word.
// The fourth byte is taken straight from the input, so the word is ready
// on the same edge that accepts it; only the first three are stored.
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);
  logic [1:0]  cnt;
  logic [23:0] sh;

  // byte position counter and shift register, restarted by a new load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sh  <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sh  <= {byte_data, sh[23:8]};
    end
  end

  assign word      = {byte_data, sh};
  assign word_done = en && (cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream writer for the instruction memory.
// Holds the core in reset until the image is fully written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     cpu_rst
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                   state, state_nx;
  logic                     accept, start_ok, word_done, err_i;
  logic [31:0]              asm_word;
  logic [ADDRESS_WIDTH-1:0] words_left, addr, n_in;

  assign byte_ready = (state == LEN) || (state == DATA) || (state == CSUM);
  assign busy       = byte_ready;
  assign accept     = byte_valid && byte_ready;
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign n_in       = ADDRESS_WIDTH'(asm_word);

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .en        (accept && ((state == LEN) || (state == DATA))),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_done (word_done)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: length word, N data words, optional checksum byte
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LEN;
      LEN:     if (word_done) state_nx = (n_in == '0) ? AFTER_DATA : DATA;
      DATA:    if (word_done && (words_left == ADDRESS_WIDTH'(1))) state_nx = AFTER_DATA;
      CSUM:    if (accept) state_nx = DONE;
      DONE:    if (start) state_nx = LEN;
      default: state_nx = IDLE;
    endcase
  end

  // word counting, address stepping and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      addr       <= '0;
      words_left <= '0;
    end else begin
      we <= 1'b0;
      if (start_ok) begin
        addr <= BASE_ADDR;
      end else if (word_done && (state == LEN)) begin
        words_left <= n_in;
      end else if (word_done && (state == DATA)) begin
        we         <= 1'b1;
        wa         <= addr;
        wd         <= DATA_WIDTH'(asm_word);
        addr       <= addr + ADDRESS_WIDTH'(WORD_BYTES);
        words_left <= words_left - ADDRESS_WIDTH'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_r;

  // running XOR of data bytes and the sticky mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum  <= '0;
      err_r <= 1'b0;
    end else if (start_ok) begin
      csum  <= '0;
      err_r <= 1'b0;
    end else if (accept && (state == DATA)) begin
      csum <= csum ^ byte_data;
    end else if (accept && (state == CSUM)) begin
      err_r <= (byte_data != csum);
    end
  end
  assign err_i = err_r;
`else
  assign err_i = 1'b0;
`endif
  assign err = err_i;

  // done flag and core reset; release lags done by one cycle so the
  // last write lands before the core starts fetching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      cpu_rst <= 1'b1;
    end else if (start_ok) begin
      done    <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      if ((state != DONE) && (state_nx == DONE)) done <= 1'b1;
      if ((state == DONE) && done && !err_i)     cpu_rst <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench. Two loaders share one byte stream, one
// at base 0 and one at base 32'hFFFFFFFC so address wrap is exercised.
module tb_imem_loader;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        ready_a, we_a, busy_a, done_a, err_a, cpu_rst_a;
  logic [31:0] wa_a, wd_a;
  logic        ready_b, we_b, busy_b, done_b, err_b, cpu_rst_b;
  logic [31:0] wa_b, wd_b;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  typedef struct {int sel; logic [31:0] exp; string name;} chk_t;
  wr_t  qa[$], qb[$];
  chk_t cq[$];
  int   total = 0, bad = 0;

  imem_loader #(.BASE_ADDR(32'h0)) ua (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_a), .we(we_a), .wa(wa_a),
    .wd(wd_a), .busy(busy_a), .done(done_a), .err(err_a), .cpu_rst(cpu_rst_a));

  imem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) ub (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_b), .we(we_b), .wa(wa_b),
    .wd(wd_b), .busy(busy_b), .done(done_b), .err(err_b), .cpu_rst(cpu_rst_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0:  return {31'd0, done_a};
      1:  return {31'd0, err_a};
      2:  return {31'd0, cpu_rst_a};
      3:  return {31'd0, busy_a};
      4:  return {31'd0, ready_a};
      5:  return {31'd0, we_a};
      6:  return wa_a;
      7:  return wd_a;
      8:  return 32'(qa.size() + qb.size());
      9:  return {31'd0, done_b};
      10: return {31'd0, cpu_rst_b};
      11: return {30'd0, err_b, busy_b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // monitor: pops expected writes on every we, then runs queued status checks
  always @(negedge clk) begin : mon
    wr_t  e;
    chk_t c;
    if (we_a) begin
      total++;
      if (qa.size() == 0) begin
        bad++; $display("FAIL wr_a got %h@%h required none", wd_a, wa_a);
      end else begin
        e = qa.pop_front();
        if ({wa_a, wd_a} !== e) begin
          bad++; $display("FAIL wr_a got %h@%h required %h@%h", wd_a, wa_a, e.d, e.a);
        end
      end
    end
    if (we_b) begin
      total++;
      if (qb.size() == 0) begin
        bad++; $display("FAIL wr_b got %h@%h required none", wd_b, wa_b);
      end else begin
        e = qb.pop_front();
        if ({wa_b, wd_b} !== e) begin
          bad++; $display("FAIL wr_b got %h@%h required %h@%h", wd_b, wa_b, e.d, e.a);
        end
      end
    end
    while (cq.size() > 0) begin
      c = cq.pop_front();
      total++;
      if (probe(c.sel) !== c.exp) begin
        bad++; $display("FAIL %s got %h required %h", c.name, probe(c.sel), c.exp);
      end
    end
  end

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    cq.push_back('{sel, exp, name});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) tick();
    byte_valid = 1'b1; byte_data = b;
    while (!ready_a && n < 20) begin tick(); n++; end
    if (!ready_a) chk(4, 32'd1, "ready_timeout");
    tick();
    byte_valid = 1'b0;
  endtask

  // builds the stream for w[], queues expected writes, sends it, checks ending
  task automatic load(input logic [31:0] w[$], input int maxgap, input bit corrupt);
    logic [7:0] s[$];
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    int n = w.size();
    for (int i = 0; i < 4; i++) s.push_back(8'((n >> (8 * i)) & 32'hFF));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = w[i][8*j +: 8];
        s.push_back(b);
        x ^= b;
      end
      qa.push_back({32'(4 * i), w[i]});
      qb.push_back({32'hFFFF_FFFC + 32'(4 * i), w[i]});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(corrupt ? ~x : x);
`endif
    pulse_start();
    chk(3, 32'd1, "busy_after_start");
    chk(0, 32'd0, "done_cleared");
    chk(1, 32'd0, "err_cleared");
    for (int i = 0; i < s.size(); i++)
      send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    chk(0, 32'd1, "done_set");
    chk(2, 32'd1, "cpu_rst_held_with_last_we");
    chk(5, (n > 0) ? 32'd1 : 32'd0, "last_we");
    chk(9, 32'd1, "done_b");
    tick();
    chk(2, corrupt ? 32'd1 : 32'd0, "cpu_rst_after_done");
    chk(1, corrupt ? 32'd1 : 32'd0, "err_final");
    chk(5, 32'd0, "we_single_cycle");
    chk(8, 32'd0, "writes_all_seen");
    tick();
  endtask

  initial begin
    logic [31:0] w[$];
    tick();
    chk(0, 32'd0, "rst_done");     chk(1, 32'd0, "rst_err");
    chk(2, 32'd1, "rst_cpu_rst");  chk(3, 32'd0, "rst_busy");
    chk(4, 32'd0, "rst_ready");    chk(5, 32'd0, "rst_we");
    chk(6, 32'd0, "rst_wa");       chk(7, 32'd0, "rst_wd");
    tick();
    rst = 1'b0;
    tick();

    w = '{32'h0000_0013, 32'h0010_0093};
    load(w, 0, 1'b0);

    w = '{};
    load(w, 0, 1'b0);

    w = '{32'h1122_3344, 32'hA5A5_5A5A, 32'h0000_00FF};
    load(w, 0, 1'b0);
    load(w, 3, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'h0000_0013, 32'h0010_0093};
    load(w, 0, 1'b1);
    load(w, 0, 1'b0);
`endif

    // reset after six bytes: length 2 plus half of word 0
    pulse_start();
    send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h78, 0); send(8'h56, 0);
    rst = 1'b1;
    #1;
    chk(0, 32'd0, "midrst_done");  chk(2, 32'd1, "midrst_cpu_rst");
    chk(3, 32'd0, "midrst_busy");  chk(4, 32'd0, "midrst_ready");
    chk(5, 32'd0, "midrst_we");    chk(6, 32'd0, "midrst_wa");
    chk(7, 32'd0, "midrst_wd");    chk(11, 32'd0, "midrst_b");
    tick();
    rst = 1'b0;
    tick();
    w = '{32'hDEAD_BEEF};
    load(w, 0, 1'b0);

    repeat (3) tick();
    chk(8, 32'd0, "final_queues_empty");
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end
endmodule
